// File: rtl/hsem_lock.sv
// Semaphore lock engine: per-semaphore owner/procid state, lock/unlock decode,
// keyed clear-all sweep and the sticky semerr vector consumed by hsem_ine.
module hsem_lock #(
    parameter int unsigned NUM_SEM = 32,
    parameter int unsigned PID_W   = 8,
    parameter logic [15:0] CLR_KEY = 16'hA5A5
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_type,
    input  logic [4:0]         req_sem,
    input  logic               req_master,
    input  logic [PID_W-1:0]   req_procid,
    input  logic [15:0]        req_key,
    output logic               rsp_valid,
    output logic               rsp_ok,
    output logic               rsp_owner,
    output logic [PID_W-1:0]   rsp_procid,
    output logic [NUM_SEM-1:0] sem_locked,
    output logic               free_evt,
    output logic [4:0]         free_idx,
    input  logic               err_clr,
    output logic [31:0]        semerr
);

    localparam int unsigned    SW        = (NUM_SEM > 1) ? $clog2(NUM_SEM) : 1;
    localparam logic [5:0]     NUM_SEM_W = 6'(NUM_SEM);
    localparam logic [SW-1:0]  LAST_IDX  = SW'(NUM_SEM - 1);

    localparam logic [1:0] REQ_RD  = 2'b00;
    localparam logic [1:0] REQ_WR  = 2'b01;
    localparam logic [1:0] REQ_UNL = 2'b10;
    localparam logic [1:0] REQ_CLR = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SW-1:0]      sweep_idx_q, sweep_idx_d;
    logic               sweep_master_q, sweep_master_d;
    logic [NUM_SEM-1:0] locked_q, locked_d;
    logic [NUM_SEM-1:0] owner_q, owner_d;
    logic [PID_W-1:0]   procid_q [NUM_SEM];
    logic [PID_W-1:0]   procid_d [NUM_SEM];
    logic               ready_q, ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_ok_q, rsp_ok_d;
    logic               rsp_owner_q, rsp_owner_d;
    logic [PID_W-1:0]   rsp_procid_q, rsp_procid_d;
    logic               free_evt_q, free_evt_d;
    logic [4:0]         free_idx_q, free_idx_d;
    logic [31:0]        semerr_q, semerr_d;

    logic [SW-1:0]      idx_s;
    logic               range_err_s;
    logic               accept_s;
    logic [4:0]         err_s;

    assign idx_s       = req_sem[SW-1:0];
    assign range_err_s = ({1'b0, req_sem} >= NUM_SEM_W);
    assign accept_s    = req_valid && ready_q;

    // Request decode, sweep sequencing and per-semaphore next state
    always_comb begin
        state_d        = state_q;
        sweep_idx_d    = sweep_idx_q;
        sweep_master_d = sweep_master_q;
        locked_d       = locked_q;
        owner_d        = owner_q;
        procid_d       = procid_q;
        ready_d        = ready_q;
        rsp_valid_d    = 1'b0;
        rsp_ok_d       = 1'b0;
        rsp_owner_d    = 1'b0;
        rsp_procid_d   = '0;
        free_evt_d     = 1'b0;
        free_idx_d     = 5'd0;
        err_s          = 5'd0;

        case (state_q)
            ST_IDLE: begin
                if (!accept_s) begin
                    ready_d = 1'b1;
                end else if (req_type == REQ_CLR) begin
                    if (req_key != CLR_KEY) begin
                        rsp_valid_d = 1'b1;
                        err_s[4]    = 1'b1;
                    end else begin
                        state_d        = ST_SWEEP;
                        sweep_idx_d    = '0;
                        sweep_master_d = req_master;
                        ready_d        = 1'b0;
                    end
                end else if (range_err_s) begin
                    rsp_valid_d = 1'b1;
                    err_s[2]    = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                    case (req_type)
                        REQ_RD: begin
                            if (!locked_q[idx_s]) begin
                                locked_d[idx_s] = 1'b1;
                                owner_d[idx_s]  = req_master;
                                procid_d[idx_s] = '0;
                                rsp_ok_d        = 1'b1;
                            end else if (owner_q[idx_s] == req_master) begin
                                rsp_ok_d = 1'b1;
                            end else begin
                                err_s[1] = 1'b1;
                            end
                        end
                        REQ_WR: begin
                            if (!locked_q[idx_s]) begin
                                locked_d[idx_s] = 1'b1;
                                owner_d[idx_s]  = req_master;
                                procid_d[idx_s] = req_procid;
                                rsp_ok_d        = 1'b1;
                            end else if ((owner_q[idx_s] == req_master) &&
                                         (procid_q[idx_s] == req_procid)) begin
                                rsp_ok_d = 1'b1;
                            end else begin
                                err_s[1] = 1'b1;
                            end
                        end
                        REQ_UNL: begin
                            if (!locked_q[idx_s]) begin
                                rsp_ok_d = 1'b1;
                            end else if (owner_q[idx_s] != req_master) begin
                                err_s[0] = 1'b1;
                            end else if (procid_q[idx_s] != req_procid) begin
                                err_s[3] = 1'b1;
                            end else begin
                                locked_d[idx_s] = 1'b0;
                                owner_d[idx_s]  = 1'b0;
                                procid_d[idx_s] = '0;
                                rsp_ok_d        = 1'b1;
                                free_evt_d      = 1'b1;
                                free_idx_d      = req_sem;
                            end
                        end
                        default: begin
                            rsp_ok_d = 1'b0;
                        end
                    endcase
                    rsp_owner_d  = owner_d[idx_s];
                    rsp_procid_d = procid_d[idx_s];
                end
            end
            ST_SWEEP: begin
                // Requests are not accepted here: ready_q is low for the whole sweep
                if (locked_q[sweep_idx_q] && (owner_q[sweep_idx_q] == sweep_master_q)) begin
                    locked_d[sweep_idx_q] = 1'b0;
                    owner_d[sweep_idx_q]  = 1'b0;
                    procid_d[sweep_idx_q] = '0;
                    free_evt_d            = 1'b1;
                    free_idx_d            = 5'(sweep_idx_q);
                end else begin
                    free_evt_d = 1'b0;
                end
                if (sweep_idx_q == LAST_IDX) begin
                    state_d     = ST_IDLE;
                    ready_d     = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_ok_d    = 1'b1;
                end else begin
                    sweep_idx_d = sweep_idx_q + SW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // Sticky error vector: a clear in the same cycle as a new error is applied first
    always_comb begin
        if (err_clr) begin
            semerr_d = 32'h0000_0000;
        end else begin
            semerr_d = semerr_q;
        end
        if (err_s != 5'd0) begin
            if (semerr_d[4:0] == 5'd0) begin
                semerr_d[12:8] = req_sem;
                semerr_d[16]   = req_master;
            end else begin
                semerr_d[24] = 1'b1;
            end
            semerr_d[4:0] = semerr_d[4:0] | err_s;
        end else begin
            semerr_d[4:0] = semerr_d[4:0];
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q        <= ST_IDLE;
            sweep_idx_q    <= '0;
            sweep_master_q <= 1'b0;
            locked_q       <= '0;
            owner_q        <= '0;
            procid_q       <= '{default: '0};
            ready_q        <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_ok_q       <= 1'b0;
            rsp_owner_q    <= 1'b0;
            rsp_procid_q   <= '0;
            free_evt_q     <= 1'b0;
            free_idx_q     <= 5'd0;
            semerr_q       <= 32'h0000_0000;
        end else begin
            state_q        <= state_d;
            sweep_idx_q    <= sweep_idx_d;
            sweep_master_q <= sweep_master_d;
            locked_q       <= locked_d;
            owner_q        <= owner_d;
            procid_q       <= procid_d;
            ready_q        <= ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_ok_q       <= rsp_ok_d;
            rsp_owner_q    <= rsp_owner_d;
            rsp_procid_q   <= rsp_procid_d;
            free_evt_q     <= free_evt_d;
            free_idx_q     <= free_idx_d;
            semerr_q       <= semerr_d;
        end
    end

    assign req_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_ok     = rsp_ok_q;
    assign rsp_owner  = rsp_owner_q;
    assign rsp_procid = rsp_procid_q;
    assign sem_locked = locked_q;
    assign free_evt   = free_evt_q;
    assign free_idx   = free_idx_q;
    assign semerr     = semerr_q;

endmodule

// File: tb/tb_hsem_lock.sv
// Testbench for hsem_lock: directed scenarios plus randomized back-to-back traffic
// checked against a semaphore-table reference model.
module tb_hsem_lock;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic [4:0]  req_sem;
    logic        req_master;
    logic [7:0]  req_procid;
    logic [15:0] req_key;
    logic        rsp_valid;
    logic        rsp_ok;
    logic        rsp_owner;
    logic [7:0]  rsp_procid;
    logic [31:0] sem_locked;
    logic        free_evt;
    logic [4:0]  free_idx;
    logic        err_clr;
    logic [31:0] semerr;

    hsem_lock dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_type   (req_type),
        .req_sem    (req_sem),
        .req_master (req_master),
        .req_procid (req_procid),
        .req_key    (req_key),
        .rsp_valid  (rsp_valid),
        .rsp_ok     (rsp_ok),
        .rsp_owner  (rsp_owner),
        .rsp_procid (rsp_procid),
        .sem_locked (sem_locked),
        .free_evt   (free_evt),
        .free_idx   (free_idx),
        .err_clr    (err_clr),
        .semerr     (semerr)
    );

    always #5 hclk = ~hclk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a table of semaphores plus the error word
    bit          m_lock [32];
    bit          m_own  [32];
    int          m_pid  [32];
    logic [31:0] m_err;
    bit          e_ok;
    bit          e_fe;
    int          e_fidx;

    function automatic logic [31:0] m_bitmap();
        logic [31:0] b;
        b = 32'h0;
        for (int i = 0; i < 32; i++) b[i] = m_lock[i];
        return b;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) begin
            m_lock[i] = 1'b0;
            m_own[i]  = 1'b0;
            m_pid[i]  = 0;
        end
        m_err = 32'h0;
    endfunction

    function automatic void m_step(int t, int s, bit m, int pid, logic [15:0] key, bit clr);
        int code;
        code   = -1;
        e_ok   = 1'b0;
        e_fe   = 1'b0;
        e_fidx = 0;
        if (t == 0) begin
            if (!m_lock[s]) begin
                m_lock[s] = 1'b1; m_own[s] = m; m_pid[s] = 0; e_ok = 1'b1;
            end else if (m_own[s] == m) e_ok = 1'b1;
            else code = 1;
        end else if (t == 1) begin
            if (!m_lock[s]) begin
                m_lock[s] = 1'b1; m_own[s] = m; m_pid[s] = pid; e_ok = 1'b1;
            end else if (m_own[s] == m && m_pid[s] == pid) e_ok = 1'b1;
            else code = 1;
        end else if (t == 2) begin
            if (!m_lock[s]) e_ok = 1'b1;
            else if (m_own[s] != m) code = 0;
            else if (m_pid[s] != pid) code = 3;
            else begin
                m_lock[s] = 1'b0; m_own[s] = 1'b0; m_pid[s] = 0;
                e_ok = 1'b1; e_fe = 1'b1; e_fidx = s;
            end
        end else begin
            if (key != 16'hA5A5) code = 4;
        end
        if (clr) m_err = 32'h0;
        if (code >= 0) begin
            if (m_err[4:0] == 5'd0) begin
                m_err[12:8] = 5'(s);
                m_err[16]   = m;
            end else begin
                m_err[24] = 1'b1;
            end
            m_err[code] = 1'b1;
        end
    endfunction

    // Present one request for exactly one edge; the model advances alongside
    task automatic issue(int t, int s, bit m, int pid, logic [15:0] key, bit clr);
        m_step(t, s, m, pid, key, clr);
        req_type   = 2'(t);
        req_sem    = 5'(s);
        req_master = m;
        req_procid = 8'(pid);
        req_key    = key;
        err_clr    = clr;
        req_valid  = 1'b1;
        @(posedge hclk);
        #1;
        req_valid  = 1'b0;
        err_clr    = 1'b0;
    endtask

    task automatic do_reset();
        hreset    = 1'b1;
        req_valid = 1'b0;
        err_clr   = 1'b0;
        @(posedge hclk);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        req_type = 2'b00; req_sem = 5'd0; req_master = 1'b0;
        req_procid = 8'd0; req_key = 16'd0;
        do_reset();
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        n_cmp++; if (sem_locked !== 32'h0) begin n_fail++; $display("FAIL reset_locked got=%h exp=0", sem_locked); end
        n_cmp++; if (semerr !== 32'h0) begin n_fail++; $display("FAIL reset_semerr got=%h exp=0", semerr); end
        n_cmp++; if ({rsp_valid, free_evt} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got=%b exp=00", {rsp_valid, free_evt}); end
    endtask

    task automatic test_lock_unlock();
        do_reset();
        issue(1, 3, 1'b0, 5, 16'h0, 1'b0);
        n_cmp++; if ({rsp_valid, rsp_ok, rsp_owner, rsp_procid} !== {1'b1, 1'b1, 1'b0, 8'd5}) begin
            n_fail++; $display("FAIL wrlock_rsp got=%b%b%b/%0d exp=110/5", rsp_valid, rsp_ok, rsp_owner, rsp_procid); end
        n_cmp++; if (sem_locked !== 32'h0000_0008) begin n_fail++; $display("FAIL wrlock_locked got=%h exp=8", sem_locked); end
        issue(0, 3, 1'b1, 0, 16'h0, 1'b0);
        n_cmp++; if (rsp_ok !== 1'b0) begin n_fail++; $display("FAIL rdlock_other_ok got=%b exp=0", rsp_ok); end
        n_cmp++; if (semerr !== 32'h0001_0302) begin n_fail++; $display("FAIL rdlock_other_err got=%h exp=00010302", semerr); end
        issue(2, 3, 1'b0, 4, 16'h0, 1'b0);
        n_cmp++; if ({rsp_ok, semerr} !== {1'b0, 32'h0101_030A}) begin
            n_fail++; $display("FAIL unlock_badpid got=%b/%h exp=0/0101030a", rsp_ok, semerr); end
        issue(2, 3, 1'b0, 5, 16'h0, 1'b0);
        n_cmp++; if ({rsp_ok, free_evt, free_idx} !== {1'b1, 1'b1, 5'd3}) begin
            n_fail++; $display("FAIL unlock_ok got=%b%b/%0d exp=11/3", rsp_ok, free_evt, free_idx); end
        n_cmp++; if (sem_locked !== 32'h0) begin n_fail++; $display("FAIL unlock_locked got=%h exp=0", sem_locked); end
        issue(2, 3, 1'b0, 5, 16'h0, 1'b0);
        n_cmp++; if ({rsp_ok, free_evt, semerr} !== {1'b1, 1'b0, 32'h0101_030A}) begin
            n_fail++; $display("FAIL unlock_free got=%b%b/%h exp=10/0101030a", rsp_ok, free_evt, semerr); end
    endtask

    task automatic test_bad_key();
        do_reset();
        issue(3, 0, 1'b0, 0, 16'h1234, 1'b0);
        n_cmp++; if ({rsp_valid, rsp_ok, req_ready, semerr} !== {3'b101, 32'h0000_0010}) begin
            n_fail++; $display("FAIL badkey_first got=%b%b%b/%h exp=101/00000010", rsp_valid, rsp_ok, req_ready, semerr); end
        issue(3, 0, 1'b1, 0, 16'h1234, 1'b0);
        n_cmp++; if (semerr !== 32'h0100_0010) begin n_fail++; $display("FAIL badkey_overflow got=%h exp=01000010", semerr); end
        err_clr = 1'b1;
        @(posedge hclk);
        #1;
        err_clr = 1'b0;
        m_err   = 32'h0;
        n_cmp++; if (semerr !== 32'h0) begin n_fail++; $display("FAIL err_clr got=%h exp=0", semerr); end
        issue(3, 0, 1'b0, 0, 16'h1234, 1'b0);
        issue(3, 0, 1'b1, 0, 16'h0000, 1'b1);
        n_cmp++; if (semerr !== 32'h0001_0010) begin n_fail++; $display("FAIL clr_and_err got=%h exp=00010010", semerr); end
    endtask

    task automatic start_sweep(bit m);
        req_type = 2'b11; req_sem = 5'd0; req_master = m; req_key = 16'hA5A5;
        req_valid = 1'b1;
        @(posedge hclk);
        #1;
        // Keep offering a request during the sweep; it must be ignored
        req_type = 2'b00; req_sem = 5'd5; req_master = 1'b1;
    endtask

    task automatic test_clear_all();
        int low_cycles;
        int got[$];
        bit done;
        do_reset();
        issue(1, 0, 1'b0, 1, 16'h0, 1'b0);
        issue(1, 7, 1'b0, 1, 16'h0, 1'b0);
        issue(0, 31, 1'b0, 0, 16'h0, 1'b0);
        issue(1, 9, 1'b1, 2, 16'h0, 1'b0);
        start_sweep(1'b0);
        for (int i = 0; i < 32; i++) if (m_lock[i] && m_own[i] == 1'b0) begin
            m_lock[i] = 1'b0; m_own[i] = 1'b0; m_pid[i] = 0;
        end
        low_cycles = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (free_evt) got.push_back(int'(free_idx));
            if (req_ready) begin
                req_valid = 1'b0;
                done = 1'b1;
            end else begin
                low_cycles++;
                @(posedge hclk);
                #1;
            end
        end
        req_valid = 1'b0;
        n_cmp++; if (!done) begin n_fail++; $display("FAIL sweep_timeout got=no_ready exp=ready"); end
        n_cmp++; if (low_cycles !== 32) begin n_fail++; $display("FAIL sweep_len got=%0d exp=32", low_cycles); end
        n_cmp++; if ({rsp_valid, rsp_ok} !== 2'b11) begin n_fail++; $display("FAIL sweep_rsp got=%b%b exp=11", rsp_valid, rsp_ok); end
        n_cmp++; if (got.size() !== 3) begin n_fail++; $display("FAIL sweep_nfree got=%0d exp=3", got.size()); end
        else begin
            n_cmp++; if ({got[0], got[1], got[2]} !== {32'd0, 32'd7, 32'd31}) begin
                n_fail++; $display("FAIL sweep_idx got=%0d,%0d,%0d exp=0,7,31", got[0], got[1], got[2]); end
        end
        n_cmp++; if (sem_locked !== 32'h0000_0200) begin n_fail++; $display("FAIL sweep_locked got=%h exp=00000200", sem_locked); end
        n_cmp++; if (semerr !== 32'h0) begin n_fail++; $display("FAIL sweep_semerr got=%h exp=0", semerr); end
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        issue(1, 2, 1'b1, 3, 16'h0, 1'b0);
        issue(1, 20, 1'b1, 3, 16'h0, 1'b0);
        issue(3, 0, 1'b0, 0, 16'h4321, 1'b0);
        start_sweep(1'b1);
        req_valid = 1'b0;
        repeat (10) @(posedge hclk);
        #1;
        n_cmp++; if (sem_locked !== 32'h0010_0000) begin n_fail++; $display("FAIL midsweep_pre got=%h exp=00100000", sem_locked); end
        hreset = 1'b1;
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        m_reset();
        n_cmp++; if ({req_ready, sem_locked, semerr} !== {1'b1, 32'h0, 32'h0}) begin
            n_fail++; $display("FAIL midsweep_reset got=%b/%h/%h exp=1/0/0", req_ready, sem_locked, semerr); end
        repeat (25) @(posedge hclk);
        #1;
        n_cmp++; if ({rsp_valid, free_evt, req_ready} !== 3'b001) begin
            n_fail++; $display("FAIL midsweep_abandon got=%b exp=001", {rsp_valid, free_evt, req_ready}); end
    endtask

    task automatic test_back_to_back();
        int t, s, pid;
        bit m, clr;
        logic [15:0] key;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            t   = $urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2);
            s   = (t == 3) ? 0 : ($urandom_range(0, 7) == 0 ? 31 : $urandom_range(0, 3));
            m   = 1'($urandom_range(0, 1));
            pid = $urandom_range(0, 2);
            key = ($urandom_range(0, 1) == 0) ? 16'h0BAD : 16'h5A5A;
            clr = ($urandom_range(0, 15) == 0);
            issue(t, s, m, pid, key, clr);
            n_cmp++; if ({rsp_valid, rsp_ok} !== {1'b1, e_ok}) begin
                n_fail++; $display("FAIL rnd_rsp n=%0d got=%b%b exp=1%b", n, rsp_valid, rsp_ok, e_ok); end
            n_cmp++; if (sem_locked !== m_bitmap()) begin
                n_fail++; $display("FAIL rnd_locked n=%0d got=%h exp=%h", n, sem_locked, m_bitmap()); end
            n_cmp++; if (semerr !== m_err) begin
                n_fail++; $display("FAIL rnd_semerr n=%0d got=%h exp=%h", n, semerr, m_err); end
            n_cmp++; if (free_evt !== e_fe || (e_fe && free_idx !== 5'(e_fidx))) begin
                n_fail++; $display("FAIL rnd_free n=%0d got=%b/%0d exp=%b/%0d", n, free_evt, free_idx, e_fe, e_fidx); end
            if (t != 3 && m_lock[s]) begin
                n_cmp++; if ({rsp_owner, rsp_procid} !== {m_own[s], 8'(m_pid[s])}) begin
                    n_fail++; $display("FAIL rnd_owner n=%0d got=%b/%0d exp=%b/%0d", n, rsp_owner, rsp_procid, m_own[s], m_pid[s]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_unlock();
        test_bad_key();
        test_clear_all();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
